// File: rtl/keypad_pkg.sv
// Shared types, widths and defaults for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int DWELL_DEFAULT    = 1000;
  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int ROW_W            = 4;
  localparam int COL_W            = 4;
  localparam int CODE_W           = 4;
  localparam int ROW_IDX_W        = 2;
  localparam int COL_IDX_W        = 2;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scanState_t;

  // Lowest-index active-low row wins when several keys share a column.
  function automatic logic [ROW_IDX_W-1:0] lowestLowRow(input logic [ROW_W-1:0] rows);
    logic [ROW_IDX_W-1:0] idx;
    idx = '0;
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (!rows[i]) idx = ROW_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [COL_W-1:0] colDrive(input logic [COL_IDX_W-1:0] idx);
    return ~(COL_W'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event bus from the scanner to its consumer.
interface keypad_scanner_if;
  import keypad_pkg::*;

  // key_valid is a one-cycle pulse with no back-pressure: the consumer must
  // take key_code on that cycle. key_held is a level for the accepted key.
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (output key_code, key_valid, key_held);
  modport slave  (input  key_code, key_valid, key_held);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad rows.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= RESET_VAL;
      syncOut <= RESET_VAL;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column dwell, debounced press/release, single-key accept.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL    = DWELL_DEFAULT,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROW_W-1:0]       row_in,
  output logic [COL_W-1:0]       col_out,
  keypad_scanner_if.master       keyBus,
  output scanState_t             dbgState
);

  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);

  logic [ROW_W-1:0]     rowSync;
  logic [DWELL_W-1:0]   dwellCnt;
  logic                 sampleTick;
  scanState_t           state;
  logic [COL_IDX_W-1:0] colIdx;
  logic [COL_IDX_W-1:0] nextCol;
  logic [ROW_IDX_W-1:0] latchedRow;
  logic [ROW_IDX_W-1:0] newRow;
  logic                 latchedLow;
  logic [CNT_W-1:0]     pressCnt;
  logic [CNT_W-1:0]     releaseCnt;
  logic [CODE_W-1:0]    keyCode;
  logic                 keyValid;
  logic                 keyHeld;

  sync_2ff #(.WIDTH(ROW_W), .RESET_VAL('1)) rowSyncInst (
    .clk     (clk),
    .rst_n   (rst_n),
    .asyncIn (row_in),
    .syncOut (rowSync)
  );

  // Free-running dwell timer; FSM transitions never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwellCnt <= '0;
    end else if (dwellCnt == DWELL_W'(DWELL - 1)) begin
      dwellCnt <= '0;
    end else begin
      dwellCnt <= dwellCnt + DWELL_W'(1);
    end
  end

  assign sampleTick = (dwellCnt == DWELL_W'(DWELL - 1));
  assign nextCol    = colIdx + COL_IDX_W'(1);
  assign newRow     = lowestLowRow(rowSync);
  assign latchedLow = !rowSync[latchedRow];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SCAN;
      colIdx     <= '0;
      col_out    <= 4'b1110;
      latchedRow <= '0;
      pressCnt   <= '0;
      releaseCnt <= '0;
      keyCode    <= '0;
      keyValid   <= 1'b0;
      keyHeld    <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      if (sampleTick) begin
        case (state)
          ST_SCAN: begin
            if (&rowSync) begin
              colIdx  <= nextCol;
              col_out <= colDrive(nextCol);
            end else begin
              latchedRow <= newRow;
              pressCnt   <= CNT_W'(1);
              if (DEBOUNCE == 1) begin
                state      <= ST_HELD;
                keyCode    <= {newRow, colIdx};
                keyValid   <= 1'b1;
                keyHeld    <= 1'b1;
                releaseCnt <= '0;
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end

          ST_DEBOUNCE: begin
            if (latchedLow) begin
              if (pressCnt + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                state      <= ST_HELD;
                keyCode    <= {latchedRow, colIdx};
                keyValid   <= 1'b1;
                keyHeld    <= 1'b1;
                releaseCnt <= '0;
              end
              pressCnt <= pressCnt + CNT_W'(1);
            end else begin
              // Bounce: give up on this key and keep scanning.
              state   <= ST_SCAN;
              colIdx  <= nextCol;
              col_out <= colDrive(nextCol);
            end
          end

          ST_HELD: begin
            if (!latchedLow) begin
              if (releaseCnt + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                state      <= ST_SCAN;
                keyHeld    <= 1'b0;
                releaseCnt <= '0;
                colIdx     <= nextCol;
                col_out    <= colDrive(nextCol);
              end else begin
                releaseCnt <= releaseCnt + CNT_W'(1);
              end
            end else begin
              releaseCnt <= '0;
            end
          end

          default: begin
            state   <= ST_SCAN;
            colIdx  <= '0;
            col_out <= 4'b1110;
          end
        endcase
      end
    end
  end

  assign keyBus.key_code  = keyCode;
  assign keyBus.key_valid = keyValid;
  assign keyBus.key_held  = keyHeld;
  assign dbgState         = state;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DWELL, default 1000, meaning clock cycles per column dwell period (minimum 2).
REQ-002 Parameter DEBOUNCE, default 4, meaning consecutive agreeing end-of-dwell samples needed to accept a press or a release (minimum 1).
REQ-003 Port clk  input  1  meaning sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  meaning reset, asynchronous assert, active-low.
REQ-005 Port row_in  input  4  meaning keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port col_out  output  4  meaning keypad column drive, active-low, exactly one bit low at all times.
REQ-007 Port key_code  output  4  meaning last accepted key, equal to row*4+col.
REQ-008 Port key_valid  output  1  meaning one-cycle pulse on the cycle key_code updates.
REQ-009 Port key_held  output  1  meaning high while an accepted key remains pressed.

Function
REQ-010 row_in SHALL pass through a two-flop synchronizer; all decisions SHALL use only the synchronized value.
REQ-011 A dwell counter SHALL count 0..DWELL-1 and wrap; "sample" means the synchronized rows on the cycle the counter equals DWELL-1.
REQ-012 The FSM SHALL have exactly three states: SCAN, DEBOUNCE, HELD.
REQ-013 In SCAN, a sample of 4'b1111 SHALL advance the active column 0->1->2->3->0; col_out changes on the cycle after the sample.
REQ-014 In SCAN, a sample with any row low SHALL freeze the column, latch the lowest-index low row, set the debounce count to 1, and enter DEBOUNCE.
REQ-015 In DEBOUNCE, a sample with the latched row still low SHALL increment the count; when the count reaches DEBOUNCE, the FSM SHALL enter HELD.
REQ-016 With DEBOUNCE=1, the FSM SHALL go directly from SCAN to HELD on the first sample.
REQ-017 In DEBOUNCE, a sample with the latched row high SHALL return the FSM to SCAN and advance the column, with no key_valid pulse.
REQ-018 On entry to HELD, key_code SHALL update and key_valid SHALL pulse high for exactly one cycle; key_held SHALL rise on the same cycle.
REQ-019 In HELD, the column SHALL stay frozen; each sample with the latched row high SHALL increment a release count, and any sample with it low SHALL clear that count.
REQ-020 When the release count reaches DEBOUNCE, the FSM SHALL enter SCAN, drop key_held, and advance the column.
REQ-021 Presses on other rows or columns during DEBOUNCE or HELD SHALL be ignored (no rollover).
REQ-022 key_code SHALL hold its value until the next acceptance; key_valid SHALL never stay high two consecutive cycles.
REQ-023 A press accepted with the same code as the previous one SHALL still pulse key_valid.
REQ-024 The dwell counter SHALL run continuously in all states and SHALL never be reset by FSM transitions.

Reset
REQ-025 While rst_n is low, the block SHALL hold: state SCAN, col_out=4'b1110, key_code=0, key_valid=0, key_held=0, all counters and synchronizer flops at 0 except synchronizer flops at 1.
REQ-026 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort the operation with no key_valid pulse; scanning resumes at column 0 on the first edge after deassertion.

Structure
REQ-027 A shared package keypad_pkg SHALL hold the state enumeration, DWELL/DEBOUNCE defaults, and the row/column/code widths.
REQ-028 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff (4 bits wide, reset value 1).

Verification (DWELL=4, DEBOUNCE=2)
REQ-029 Reset: hold rst_n low with row_in=4'b0000 -> col_out=4'b1110, key_valid=0, key_held=0, key_code=0 throughout.
REQ-030 Idle scan: row_in=4'b1111 for 32 cycles -> col_out cycles 1110,1101,1011,0111, each held 4 cycles, then wraps.
REQ-031 Clean press: pull row 2 low whenever column 1 is driven, for 12 cycles -> single key_valid pulse with key_code=9 and key_held=1. Release -> key_held falls after 2 high samples and scanning resumes at column 2.
REQ-032 Bounce: row 0 low for one sample at column 3, then high -> no key_valid pulse, FSM back in SCAN, col_out=4'b1110 next.
REQ-033 Multi-key: rows 1 and 3 low together at column 0 -> key_code=4. A later press at column 2 while held -> ignored.
REQ-034 Reset mid-HELD: assert rst_n during HELD -> key_held=0 immediately; no key_valid after deassertion until a fresh press is debounced.
